mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for the shared unified memory of the multi-cycle core.
// Fixed CPU priority, DMA anti-starvation override, hung-access timeout.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_done,
  output logic              dma_err,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    CPU_ACC,
    DMA_ACC
  } state_t;

  state_t          state, state_nx;
  logic [WW-1:0]   wait_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            we_lat;
  logic            cpu_elig, dma_elig, dma_win;
  logic            grant_cpu, grant_dma;
  logic            acc, tmo_hit;

  assign acc       = (state != IDLE);
  assign mem_rd    = acc & ~we_lat;
  assign mem_wr    = acc & we_lat;
  assign cpu_stall = cpu_req & ~cpu_done;
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));

  // A port whose done/err is showing this cycle may not be re-granted yet
  assign cpu_elig = cpu_req & ~cpu_done & ~cpu_err;
  assign dma_elig = dma_req & ~dma_done & ~dma_err;
  assign dma_win  = dma_elig &
                    (~cpu_elig | (wait_cnt >= WW'(MAX_WAIT)));

  always_comb begin
    state_nx  = state;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          dma_win: begin
            grant_dma = 1'b1;
            state_nx  = DMA_ACC;
          end
          cpu_elig: begin
            grant_cpu = 1'b1;
            state_nx  = CPU_ACC;
          end
          default: state_nx = IDLE;
        endcase
      end
      CPU_ACC, DMA_ACC: begin
        if (mem_ready || tmo_hit)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      we_lat    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nx;
      if (grant_dma) begin
        we_lat    <= dma_we;
        mem_addr  <= dma_addr;
        mem_wdata <= dma_wdata;
      end else if (grant_cpu) begin
        we_lat    <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      if (acc && !mem_ready && !tmo_hit)
        tmo_cnt <= tmo_cnt + TW'(1);
      else
        tmo_cnt <= '0;
      if (!dma_req || grant_dma)
        wait_cnt <= '0;
      else if (state != DMA_ACC && wait_cnt != WW'(MAX_WAIT))
        wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // mem_ready on the limit cycle still counts as success
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      dma_done  <= 1'b0;
      dma_err   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      cpu_done <= (state == CPU_ACC) & mem_ready;
      cpu_err  <= (state == CPU_ACC) & ~mem_ready & tmo_hit;
      dma_done <= (state == DMA_ACC) & mem_ready;
      dma_err  <= (state == DMA_ACC) & ~mem_ready & tmo_hit;
      if (state == CPU_ACC && mem_ready && !we_lat)
        cpu_rdata <= mem_rdata;
      if (state == DMA_ACC && mem_ready && !we_lat)
        dma_rdata <= mem_rdata;
    end
  end

endmodule
